// File: rtl/axis_insert_arbiter.sv
// Packet-level round-robin arbiter feeding one header inserter (hdr -> s00, data -> s01).
// Caps in-flight packets by snooping the inserter's output tlast handshake.
//   state    | meaning
//   ST_IDLE  | no grant held; pick next requester when below the in-flight limit
//   ST_GRANT | pass through grant_id's header beat and data beats up to tlast
module axis_insert_arbiter #(
   parameter int DATA_WD         = 32,
   parameter int DATA_BYTE_WD    = DATA_WD/8,
   parameter int NUM_CH          = 4,
   parameter int CH_WD           = $clog2(NUM_CH),
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CH-1:0]              s_hdr_tvalid,
   input  logic [NUM_CH*DATA_WD-1:0]      s_hdr_tdata,
   input  logic [NUM_CH*DATA_BYTE_WD-1:0] s_hdr_tkeep,
   output logic [NUM_CH-1:0]              s_hdr_tready,
   input  logic [NUM_CH-1:0]              s_dat_tvalid,
   input  logic [NUM_CH*DATA_WD-1:0]      s_dat_tdata,
   input  logic [NUM_CH*DATA_BYTE_WD-1:0] s_dat_tkeep,
   input  logic [NUM_CH-1:0]              s_dat_tlast,
   output logic [NUM_CH-1:0]              s_dat_tready,
   output logic                           m_hdr_tvalid,
   output logic [DATA_WD-1:0]             m_hdr_tdata,
   output logic [DATA_BYTE_WD-1:0]        m_hdr_tkeep,
   input  logic                           m_hdr_tready,
   output logic                           m_dat_tvalid,
   output logic [DATA_WD-1:0]             m_dat_tdata,
   output logic [DATA_BYTE_WD-1:0]        m_dat_tkeep,
   output logic                           m_dat_tlast,
   input  logic                           m_dat_tready,
   input  logic                           mon_tvalid,
   input  logic                           mon_tready,
   input  logic                           mon_tlast,
   output logic [CH_WD-1:0]               grant_id,
   output logic                           busy,
   output logic [3:0]                     outstanding
);

   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CH_WD-1:0] r_rr_ptr;
   logic [CH_WD-1:0] r_grant_id;
   logic             r_hdr_done;
   logic             r_dat_done;
   logic [3:0]       r_outstanding;

   logic             w_req_any;
   logic [CH_WD-1:0] w_winner;
   logic             w_grant_start;
   logic             w_sel_hvalid;
   logic             w_sel_dvalid;
   logic             w_hdr_hs;
   logic             w_dat_last_hs;
   logic             w_pkt_done;
   logic             w_mon_last;
   logic [CH_WD-1:0] w_rr_nxt;

   // Descending scan so the requester closest to r_rr_ptr is the one left standing.
   always_comb begin
      w_req_any = 1'b0;
      w_winner  = '0;
      for (int k = NUM_CH-1; k >= 0; k--) begin
         if (s_hdr_tvalid[(int'(r_rr_ptr) + k) % NUM_CH]) begin
            w_req_any = 1'b1;
            w_winner  = CH_WD'((int'(r_rr_ptr) + k) % NUM_CH);
         end
      end
   end

   assign busy          = (r_state == ST_GRANT);
   assign w_grant_start = (r_state == ST_IDLE) && w_req_any &&
                          (r_outstanding < 4'(MAX_OUTSTANDING));

   always_comb begin
      w_sel_hvalid = 1'b0;
      w_sel_dvalid = 1'b0;
      m_hdr_tdata  = '0;
      m_hdr_tkeep  = '0;
      m_dat_tdata  = '0;
      m_dat_tkeep  = '0;
      m_dat_tlast  = 1'b0;
      s_hdr_tready = '0;
      s_dat_tready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_grant_id == CH_WD'(i)) begin
            w_sel_hvalid    = s_hdr_tvalid[i];
            w_sel_dvalid    = s_dat_tvalid[i];
            m_hdr_tdata     = s_hdr_tdata[i*DATA_WD +: DATA_WD];
            m_hdr_tkeep     = s_hdr_tkeep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
            m_dat_tdata     = s_dat_tdata[i*DATA_WD +: DATA_WD];
            m_dat_tkeep     = s_dat_tkeep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
            m_dat_tlast     = s_dat_tlast[i];
            s_hdr_tready[i] = busy & m_hdr_tready & ~r_hdr_done;
            s_dat_tready[i] = busy & m_dat_tready & ~r_dat_done;
         end
      end
      m_hdr_tvalid = busy & w_sel_hvalid & ~r_hdr_done;
      m_dat_tvalid = busy & w_sel_dvalid & ~r_dat_done;
   end

   assign w_hdr_hs      = m_hdr_tvalid & m_hdr_tready;
   assign w_dat_last_hs = m_dat_tvalid & m_dat_tready & m_dat_tlast;
   assign w_pkt_done    = busy & (r_hdr_done | w_hdr_hs) & (r_dat_done | w_dat_last_hs);
   assign w_mon_last    = mon_tvalid & mon_tready & mon_tlast;
   assign w_rr_nxt      = (r_grant_id == CH_WD'(NUM_CH-1)) ? '0 : r_grant_id + CH_WD'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_grant_start) w_state_nxt = ST_GRANT;
         ST_GRANT: if (w_pkt_done)    w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_hdr_done <= 1'b0;
         r_dat_done <= 1'b0;
      end else if (w_grant_start) begin
         r_grant_id <= w_winner;
         r_hdr_done <= 1'b0;
         r_dat_done <= 1'b0;
      end else if (busy) begin
         if (w_hdr_hs)      r_hdr_done <= 1'b1;
         if (w_dat_last_hs) r_dat_done <= 1'b1;
         if (w_pkt_done)    r_rr_ptr   <= w_rr_nxt;
      end
   end

   // A grant and an output tlast in the same cycle cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_outstanding <= '0;
      else if (w_grant_start && !w_mon_last)
         r_outstanding <= r_outstanding + 4'd1;
      else if (!w_grant_start && w_mon_last && (r_outstanding != 4'd0))
         r_outstanding <= r_outstanding - 4'd1;
   end

   assign grant_id    = r_grant_id;
   assign outstanding = r_outstanding;

endmodule

// File: doc/axis_insert_arbiter.md
Name: axis_insert_arbiter

Overview:
- Packet-level round-robin arbiter that shares one DataInserterStream-class header inserter between NUM_CH requesters. Each requester has a header stream and a data stream.
- Grants one channel per packet and passes through its header beat and all of its data beats up to and including tlast. It then re-arbitrates.
- Sits directly upstream of the inserter's s00/s01 ports. It snoops the inserter's m_axis handshake to limit how many packets are in flight.

Parameters:
- DATA_WD, 32, data width in bits.
- DATA_BYTE_WD, DATA_WD/8, keep width.
- NUM_CH, 4, number of requesters (2..16).
- CH_WD, $clog2(NUM_CH), width of the grant index.
- MAX_OUTSTANDING, 2, maximum number of packets granted but whose output tlast is not yet seen (1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_hdr_tvalid  in  NUM_CH  per-channel header valid.
- s_hdr_tdata  in  NUM_CH*DATA_WD  headers, channel i at [i*DATA_WD +: DATA_WD].
- s_hdr_tkeep  in  NUM_CH*DATA_BYTE_WD  header keeps.
- s_hdr_tready  out  NUM_CH  header ready.
- s_dat_tvalid  in  NUM_CH  data valid.
- s_dat_tdata  in  NUM_CH*DATA_WD  data.
- s_dat_tkeep  in  NUM_CH*DATA_BYTE_WD  data keeps.
- s_dat_tlast  in  NUM_CH  data last.
- s_dat_tready  out  NUM_CH  data ready.
- m_hdr_tvalid/tdata/tkeep  out  1/DATA_WD/DATA_BYTE_WD  to inserter s00.
- m_hdr_tready  in  1  from inserter s00.
- m_dat_tvalid/tdata/tkeep/tlast  out  1/DATA_WD/DATA_BYTE_WD/1  to inserter s01.
- m_dat_tready  in  1  from inserter s01.
- mon_tvalid, mon_tready, mon_tlast  in  1 each  snoop of the inserter m_axis handshake.
- grant_id  out  CH_WD  current or last granted channel.
- busy  out  1  high while in GRANT state.
- outstanding  out  4  in-flight packet count.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0, grant_id=0, hdr_done=0, dat_done=0, outstanding=0.
  - All tready and m_*_tvalid outputs low.
  - Outputs are combinational from these registers, so they are low during reset.
- FSM states: IDLE, GRANT.
- IDLE:
  - A request is s_hdr_tvalid[i]=1.
  - If any request exists and outstanding<MAX_OUTSTANDING: pick the first requesting channel at or after rr_ptr, wrapping modulo NUM_CH.
  - Next edge: grant_id<=winner, hdr_done<=0, dat_done<=0, state<=GRANT.
  - Otherwise stay in IDLE. All readies and m valids are 0 in IDLE.
- GRANT, with g=grant_id; zero-latency combinational pass-through:
  - m_hdr_tvalid = s_hdr_tvalid[g] & !hdr_done; data/keep muxed from channel g.
  - s_hdr_tready[g] = m_hdr_tready & !hdr_done.
  - m_dat_tvalid = s_dat_tvalid[g] & !dat_done; data/keep/last muxed from channel g.
  - s_dat_tready[g] = m_dat_tready & !dat_done.
  - Readies of non-granted channels are 0.
  - Header handshake sets hdr_done. Data handshake with tlast=1 sets dat_done.
  - Completion condition: (hdr_done or header handshake this cycle) AND (dat_done or data tlast handshake this cycle). Both may fall in the same cycle.
  - On completion: state<=IDLE, rr_ptr<=(g+1) mod NUM_CH. The earliest re-grant is one cycle later.
  - Data beats before the header handshake pass through; the inserter buffers them.
- outstanding counter:
  - +1 on the IDLE->GRANT transition.
  - −1 on mon_tvalid&mon_tready&mon_tlast.
  - Both in the same cycle: unchanged.
  - Saturates at 0: a spurious decrement is ignored. It never exceeds MAX_OUTSTANDING, because the grant is blocked at the limit.
- busy = (state==GRANT). grant_id holds its value in IDLE.
- Requests that drop in IDLE are simply not seen. Once a channel is granted, its streams follow AXIS rules; a valid is not withdrawn.

Test Plan:
- Single channel: ch1 header 0xAABBCCDD keep 0xF, data 3 beats with last on beat 3, all readies high. Expected: grant_id=1 one cycle after the request; m_hdr and m_dat beats are bit-exact copies of ch1; busy high for 3 cycles; outstanding=1 until a mon tlast, then 0.
- Round robin: all 4 channels request continuously with 1-beat packets; mon tlast pulses after each packet. Expected: grant order 0,1,2,3,0; no other channel's readies ever go high.
- Outstanding limit, MAX_OUTSTANDING=2: three queued packets, no mon tlast. Expected: two packets granted; outstanding=2; third stays in IDLE with no readies. One mon tlast pulse, then the third is granted the next cycle.
- Simultaneous events: header handshake and data tlast handshake in the same cycle. Expected: GRANT->IDLE at that edge. Separately, a grant and a mon tlast in the same cycle leave outstanding unchanged.
- Backpressure: m_hdr_tready low for 5 cycles while data flows. Expected: data beats pass; the header is held stable; completion waits for the header handshake; no data beats are lost or duplicated.
- Reset mid-packet: assert rst_n=0 after beat 2 of 4. Expected: all valids and readies 0 immediately; after release, outstanding=0, rr_ptr=0, and the next grant goes to the lowest requesting channel.
